reg_write_scheduler: RTL and testbench
======================================

// Module: reg_write_scheduler
// PURPOSE
//   Round-robin write-port scheduler for a bank of 5-bit load-enable registers in the CPU datapath.
//   Several requesters (ALU writeback, load unit, immediate path) share one write path into NREG registers.
//   Grants one request at a time, drives the winning register's sel and the shared data bus.
//   Fair arbitration: the last winner gets lowest priority.
// PARAMETERS
//   NREQ  3  number of requesters (2..8)
//   NREG  4  number of destination registers (power of 2)
//   DW    5  data width, matches register width
//   AW    2  register address width, = log2(NREG)
// PORTS
//   clk       in   1         rising-edge clock
//   rst       in   1         synchronous reset, active-high
//   req       in   NREQ      per-requester write request, level
//   req_addr  in   NREQ*AW   packed dest address; requester i at [i*AW +: AW]
//   req_data  in   NREQ*DW   packed write data; requester i at [i*DW +: DW]
//   gnt       out  NREQ      one-hot grant pulse, registered
//   reg_sel   out  NREG      one-hot load enable to register bank, registered
//   reg_din   out  DW        shared data to register bank, registered
//   busy      out  1         high while in WRITE state
// BEHAVIOUR
//   - FSM states: IDLE, WRITE. Reset state IDLE.
//   - Reset (rst high at clock edge): gnt=0, reg_sel=0, reg_din=0, busy=0, rr_ptr=NREQ-1, state=IDLE.
//   - rr_ptr initialised to NREQ-1, so requester 0 has top priority after reset.
//   - IDLE, req==0: stay IDLE; all outputs 0.
//   - IDLE, req!=0 at edge k: winner w = first set req bit searching w = rr_ptr+1, rr_ptr+2, ... modulo NREQ.
//     - Same edge k: latch addr[w] and data[w], set rr_ptr=w, go to WRITE.
//   - WRITE (cycle after edge k): gnt[w]=1, reg_sel[addr[w]]=1, reg_din=data[w], busy=1.
//     - The register bank loads at edge k+1. The FSM returns to IDLE at edge k+1.
//     - At edge k+1, gnt, reg_sel and busy return to 0. reg_din holds its last value.
//   - Latency: req sampled at edge k; register content updated at edge k+1.
//   - Throughput: at most one write every 2 cycles.
//   - req is sampled only in IDLE. A requester must hold req until it sees gnt, then drop it.
//     - If req is still high in the IDLE cycle after gnt, it is treated as a new request.
//   - Changes to req, req_addr or req_data during WRITE are ignored. The latched write completes.
//   - Simultaneous requests: exactly one grant. The others stay pending and are served in rotation.
//   - With all NREQ requests held continuously, each requester is granted once every 2*NREQ cycles.
//   - Exactly one reg_sel bit is high in WRITE; all bits are 0 in IDLE.
//     - A multi-hot or spurious reg_sel is an error.
//   - Reset mid-WRITE: rst has priority. The next cycle shows all outputs 0.
//     - The pending grant is lost; the requester re-requests.
// CONFIGURATION
//   WRITE_COUNT_EN defined:
//     - Adds output port wr_count [7:0]: number of completed writes.
//     - Increments at each WRITE->IDLE transition. Wraps 255->0. Reset value 0.
//   WRITE_COUNT_EN undefined:
//     - No wr_count port, no counter logic.
//     - All other behaviour is identical.
// TESTING
//   1 Single write: req=001, addr0=2, data0=5'b10011 -> next cycle gnt=001, reg_sel=0100, reg_din=10011, busy=1.
//     - Cycle after that: gnt, reg_sel and busy are all 0.
//   2 Simultaneous: after reset, req=111 held continuously, addrs 0/1/3 -> grant order 0,1,2,0.
//     - gnt is high every other cycle; reg_sel follows 0001, 0010, 1000, 0001.
//   3 Fairness: after requester 1 wins, req=011 -> requester 0 is granted next, not requester 1.
//   4 Idle stability: req=000 for 10 cycles -> gnt, reg_sel and busy stay 0; reg_din holds its last value.
//   5 Reset mid-write: rst=1 during the WRITE cycle -> next cycle all outputs 0, state IDLE.
//     - With req=111 held, requester 0 is granted first afterwards.
//   6 WRITE_COUNT_EN build: 257 writes -> wr_count reads 1.
//     - Without the macro: the build has no wr_count port and scenarios 1-5 pass.

Source files
------------

// File: rtl/reg_write_scheduler.sv
// Round-robin write-port scheduler driving a bank of load-enable registers.
// Optional macro WRITE_COUNT_EN adds an 8-bit completed-write counter port wr_count.
module reg_write_scheduler #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned NREG = 4,
  parameter int unsigned DW   = 5,
  parameter int unsigned AW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    reg_sel,
  output logic [DW-1:0]      reg_din,
  output logic               busy
`ifdef WRITE_COUNT_EN
  ,
  output logic [7:0]         wr_count
`endif
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;
  logic [AW-1:0] addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_a[i] = req_addr[i*AW +: AW];
      data_a[i] = req_data[i*DW +: DW];
    end
  end

  // Search starts just past the last winner so it ends up with lowest priority.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = PW'((32'(rr_ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      reg_sel  <= '0;
      reg_din  <= '0;
      busy     <= 1'b0;
      rr_ptr   <= PW'(NREQ - 1);
`ifdef WRITE_COUNT_EN
      wr_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt     <= NREQ'(1) << win;
            reg_sel <= NREG'(1) << addr_a[win];
            reg_din <= data_a[win];
            busy    <= 1'b1;
            rr_ptr  <= win;
            state   <= WRITE;
          end
        end
        WRITE: begin
          // reg_din deliberately keeps the last written value.
          gnt     <= '0;
          reg_sel <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
`ifdef WRITE_COUNT_EN
          wr_count <= wr_count + 8'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Scoreboard bench for reg_write_scheduler: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever the DUT shows a grant.
module tb_reg_write_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [5:0]  req_addr = '0;
  logic [14:0] req_data = '0;
  logic [2:0]  gnt;
  logic [3:0]  reg_sel;
  logic [4:0]  reg_din;
  logic        busy;
`ifdef WRITE_COUNT_EN
  logic [7:0]  wr_count;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] g;
    logic [3:0] s;
    logic [4:0] d;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  reg_write_scheduler #(
    .NREQ(3),
    .NREG(4),
    .DW  (5),
    .AW  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .req_addr(req_addr),
    .req_data(req_data),
    .gnt     (gnt),
    .reg_sel (reg_sel),
    .reg_din (reg_din),
    .busy    (busy)
`ifdef WRITE_COUNT_EN
    ,
    .wr_count(wr_count)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] g, input logic [3:0] s, input logic [4:0] d);
    exp_t e;
    e.g = g;
    e.s = s;
    e.d = d;
    q.push_back(e);
  endtask

  task automatic check_idle(input string name, input logic [4:0] din);
    chk(name, {19'b0, gnt, reg_sel, busy, reg_din}, {19'b0, 3'b000, 4'b0000, 1'b0, din});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: any visible grant must match the oldest expected write.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1 || (|gnt) === 1'b1 || (|reg_sel) === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got gnt=%b sel=%b din=%b busy=%b want no write",
                 gnt, reg_sel, reg_din, busy);
      end else begin
        e = q.pop_front();
        chk("write", {19'b0, gnt, reg_sel, reg_din, busy}, {19'b0, e.g, e.s, e.d, 1'b1});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    step();
    check_idle("reset", 5'b00000);
    rst = 1'b0;

    // 1: single write from requester 0 to register 2
    req_addr = 6'b00_00_10;
    req_data = {5'b0, 5'b0, 5'b10011};
    req      = 3'b001;
    push(3'b001, 4'b0100, 5'b10011);
    step();
    req = 3'b000;
    step();
    check_idle("t1_after", 5'b10011);

    // 2: all three requesting, grants rotate 0,1,2,0
    do_reset();
    req_addr = {2'd3, 2'd1, 2'd0};
    req_data = {5'h04, 5'h02, 5'h01};
    req      = 3'b111;
    push(3'b001, 4'b0001, 5'h01);
    push(3'b010, 4'b0010, 5'h02);
    push(3'b100, 4'b1000, 5'h04);
    push(3'b001, 4'b0001, 5'h01);
    repeat (7) step();
    req = 3'b000;
    step();
    check_idle("t2_after", 5'h01);

    // 3: after requester 1 wins, 011 goes to requester 0
    do_reset();
    req = 3'b010;
    push(3'b010, 4'b0010, 5'h02);
    step();
    req = 3'b011;
    push(3'b001, 4'b0001, 5'h01);
    step();
    step();
    req = 3'b000;
    step();
    check_idle("t3_after", 5'h01);

    // 4: idle stability, reg_din holds
    repeat (10) begin
      step();
      check_idle("t4_idle", 5'h01);
    end

    // 5: reset during WRITE, then requester 0 wins first
    req = 3'b111;
    push(3'b010, 4'b0010, 5'h02);
    step();
    rst = 1'b1;
    step();
    check_idle("t5_reset", 5'b00000);
    rst = 1'b0;
    push(3'b001, 4'b0001, 5'h01);
    step();
    req = 3'b000;
    step();
    check_idle("t5_after", 5'h01);

`ifdef WRITE_COUNT_EN
    // 6: 257 completed writes wrap the counter to 1
    do_reset();
    chk("count_reset", {24'b0, wr_count}, 32'd0);
    req = 3'b001;
    for (int n = 0; n < 257; n++) push(3'b001, 4'b0001, 5'h01);
    repeat (513) step();
    req = 3'b000;
    step();
    chk("count_wrap", {24'b0, wr_count}, 32'd1);
`endif

    step();
    chk("queue_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
